// File: rtl/rv_alu_arb_if.sv
// ---------------------------------------------------------------------------
// rv_alu_arb_if
// Handshake bundle between two ALU requesters plus one result consumer
// (master side) and the rv_alu_arb arbiter (slave side).
//
// Signals (directions as seen by the arbiter):
//   i_flush                      in   discard the held result
//   i_reqN_valid                 in   request N valid (N = 0, 1)
//   o_reqN_ready                 out  request N accepted this cycle
//   i_reqN_src_a, i_reqN_src_b   in   32-bit operands of request N
//   i_reqN_ctrl                  in   5-bit ALU control of request N
//   i_reqN_tag                   in   TAG_W-bit opaque tag of request N
//   o_rsp_valid                  out  result register holds a result
//   i_rsp_ready                  in   consumer takes the result this cycle
//   o_rsp_result, o_rsp_zero     out  registered ALU result and zero flag
//   o_rsp_id, o_rsp_tag          out  winning requester and its tag
// ---------------------------------------------------------------------------
interface rv_alu_arb_if #(
    parameter int TAG_W = 4
);
    logic             i_flush;

    logic             i_req0_valid;
    logic             o_req0_ready;
    logic [31:0]      i_req0_src_a;
    logic [31:0]      i_req0_src_b;
    logic [4:0]       i_req0_ctrl;
    logic [TAG_W-1:0] i_req0_tag;

    logic             i_req1_valid;
    logic             o_req1_ready;
    logic [31:0]      i_req1_src_a;
    logic [31:0]      i_req1_src_b;
    logic [4:0]       i_req1_ctrl;
    logic [TAG_W-1:0] i_req1_tag;

    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [31:0]      o_rsp_result;
    logic             o_rsp_zero;
    logic             o_rsp_id;
    logic [TAG_W-1:0] o_rsp_tag;

    // Requesters and consumer drive the request fields and take the results.
    modport master (
        output i_flush,
        output i_req0_valid, i_req0_src_a, i_req0_src_b, i_req0_ctrl, i_req0_tag,
        output i_req1_valid, i_req1_src_a, i_req1_src_b, i_req1_ctrl, i_req1_tag,
        output i_rsp_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_rsp_valid, o_rsp_result, o_rsp_zero, o_rsp_id, o_rsp_tag
    );

    // The arbiter consumes requests and produces readys and results.
    modport slave (
        input  i_flush,
        input  i_req0_valid, i_req0_src_a, i_req0_src_b, i_req0_ctrl, i_req0_tag,
        input  i_req1_valid, i_req1_src_a, i_req1_src_b, i_req1_ctrl, i_req1_tag,
        input  i_rsp_ready,
        output o_req0_ready, o_req1_ready,
        output o_rsp_valid, o_rsp_result, o_rsp_zero, o_rsp_id, o_rsp_tag
    );
endinterface

// File: rtl/rv_alu_arb.sv
// ---------------------------------------------------------------------------
// rv_alu_arb
// Two-requester round-robin front end for a single shared rv_alu. The
// granted request's operands are muxed into the ALU; on accept the ALU
// output, the requester id and its tag are captured in a one-entry result
// register that is handed to the consumer with a valid/ready handshake.
// Accept and consume in the same cycle sustain one result per cycle.
//
// Ports:
//   i_clk    in   single clock, rising edge
//   i_reset  in   asynchronous active-high reset
//   bus      slave modport of rv_alu_arb_if (requests, readys, result)
//
// Also contains rv_alu, the shared combinational ALU.
//   ALU control encoding (5 bits):
//     00000 ADD   00001 SUB   00010 SLL   00011 XOR
//     00100 SRL   00101 SRA   00110 OR    00111 AND
//     10000 CMP_EQ   10001 CMP_NE   10100 CMP_LT
//     10101 CMP_GE   10110 CMP_LTU  10111 CMP_GEU
//   Compares return 1 or 0 in the 32-bit result. zero = (result == 0).
// ---------------------------------------------------------------------------

`ifndef RV_ALU_DEFINES
`define RV_ALU_DEFINES
`define ALU_CTRL_ADD  5'b00000
`define ALU_CTRL_SUB  5'b00001
`define ALU_CTRL_SLL  5'b00010
`define ALU_CTRL_XOR  5'b00011
`define ALU_CTRL_SRL  5'b00100
`define ALU_CTRL_SRA  5'b00101
`define ALU_CTRL_OR   5'b00110
`define ALU_CTRL_AND  5'b00111
`define ALU_CMP_EQ    5'b10000
`define ALU_CMP_NE    5'b10001
`define ALU_CMP_LT    5'b10100
`define ALU_CMP_GE    5'b10101
`define ALU_CMP_LTU   5'b10110
`define ALU_CMP_GEU   5'b10111
`endif

module rv_alu (
    input  logic [31:0] i_src_a,
    input  logic [31:0] i_src_b,
    input  logic [4:0]  i_ctrl,
    output logic [31:0] o_result,
    output logic        o_zero
);
    // Turns a compare outcome into the 32-bit 0/1 result form.
    function automatic logic [31:0] flag32(input logic f);
        return {31'd0, f};
    endfunction

    // Result selection by control code; unknown codes produce 0.
    always_comb begin
        o_result = 32'd0;
        case (i_ctrl)
            `ALU_CTRL_ADD: o_result = i_src_a + i_src_b;
            `ALU_CTRL_SUB: o_result = i_src_a - i_src_b;
            `ALU_CTRL_SLL: o_result = i_src_a << i_src_b[4:0];
            `ALU_CTRL_XOR: o_result = i_src_a ^ i_src_b;
            `ALU_CTRL_SRL: o_result = i_src_a >> i_src_b[4:0];
            `ALU_CTRL_SRA: o_result = $unsigned($signed(i_src_a) >>> i_src_b[4:0]);
            `ALU_CTRL_OR:  o_result = i_src_a | i_src_b;
            `ALU_CTRL_AND: o_result = i_src_a & i_src_b;
            `ALU_CMP_EQ:   o_result = flag32(i_src_a == i_src_b);
            `ALU_CMP_NE:   o_result = flag32(i_src_a != i_src_b);
            `ALU_CMP_LT:   o_result = flag32($signed(i_src_a) < $signed(i_src_b));
            `ALU_CMP_GE:   o_result = flag32($signed(i_src_a) >= $signed(i_src_b));
            `ALU_CMP_LTU:  o_result = flag32(i_src_a < i_src_b);
            `ALU_CMP_GEU:  o_result = flag32(i_src_a >= i_src_b);
            default:       o_result = 32'd0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);
endmodule

module rv_alu_arb #(
    parameter int TAG_W = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    rv_alu_arb_if.slave   bus
);
    // Round-robin pointer: requester favoured when both are valid.
    logic             rr_q, rr_d;

    // Result register.
    logic             rsp_valid_q,  rsp_valid_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_zero_q,   rsp_zero_d;
    logic             rsp_id_q,     rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q,    rsp_tag_d;

    logic             grant0_s, grant1_s;
    logic             slot_free_s;
    logic             ready0_s, ready1_s;
    logic             accept0_s, accept1_s, accept_s;
    logic [31:0]      alu_a_s, alu_b_s, alu_res_s;
    logic [4:0]       alu_ctrl_s;
    logic             alu_zero_s;
    logic [TAG_W-1:0] sel_tag_s;

    // Grant: a lone valid requester wins; on contention rr decides.
    always_comb begin
        grant0_s = bus.i_req0_valid & (~bus.i_req1_valid | (rr_q == 1'b0));
        grant1_s = bus.i_req1_valid & (~bus.i_req0_valid | (rr_q == 1'b1));
    end

    // Readys: the slot frees when empty or being drained this cycle. Flush
    // and reset block acceptance so nothing enters a register being cleared.
    always_comb begin
        slot_free_s = ~rsp_valid_q | bus.i_rsp_ready;
        ready0_s    = grant0_s & slot_free_s & ~bus.i_flush & ~i_reset;
        ready1_s    = grant1_s & slot_free_s & ~bus.i_flush & ~i_reset;
        accept0_s   = bus.i_req0_valid & ready0_s;
        accept1_s   = bus.i_req1_valid & ready1_s;
        accept_s    = accept0_s | accept1_s;
    end

    // Operand mux into the shared ALU, steered by the current grant.
    always_comb begin
        if (grant1_s) begin
            alu_a_s    = bus.i_req1_src_a;
            alu_b_s    = bus.i_req1_src_b;
            alu_ctrl_s = bus.i_req1_ctrl;
            sel_tag_s  = bus.i_req1_tag;
        end else begin
            alu_a_s    = bus.i_req0_src_a;
            alu_b_s    = bus.i_req0_src_b;
            alu_ctrl_s = bus.i_req0_ctrl;
            sel_tag_s  = bus.i_req0_tag;
        end
    end

    rv_alu u_alu (
        .i_src_a  (alu_a_s),
        .i_src_b  (alu_b_s),
        .i_ctrl   (alu_ctrl_s),
        .o_result (alu_res_s),
        .o_zero   (alu_zero_s)
    );

    // Next state of result register and rr; flush beats consume, and an
    // accept overlapping a consume simply reloads with valid kept high.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_id_d     = rsp_id_q;
        rsp_tag_d    = rsp_tag_q;
        rr_d         = rr_q;
        if (bus.i_flush) begin
            rsp_valid_d = 1'b0;
        end else if (accept_s) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_res_s;
            rsp_zero_d   = alu_zero_s;
            rsp_id_d     = accept1_s;
            rsp_tag_d    = sel_tag_s;
            rr_d         = ~accept1_s;
        end else if (rsp_valid_q && bus.i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 32'd0;
            rsp_zero_q   <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_tag_q    <= '0;
            rr_q         <= 1'b0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_id_q     <= rsp_id_d;
            rsp_tag_q    <= rsp_tag_d;
            rr_q         <= rr_d;
        end
    end

    assign bus.o_req0_ready = ready0_s;
    assign bus.o_req1_ready = ready1_s;
    assign bus.o_rsp_valid  = rsp_valid_q;
    assign bus.o_rsp_result = rsp_result_q;
    assign bus.o_rsp_zero   = rsp_zero_q;
    assign bus.o_rsp_id     = rsp_id_q;
    assign bus.o_rsp_tag    = rsp_tag_q;
endmodule

// File: doc/rv_alu_arb.md
RV_ALU_ARB -- requirements
Module: rv_alu_arb

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the requester transaction tag.
REQ-002 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_flush  input  1  synchronous discard of the held result.
REQ-005 SHALL have ports i_reqN_valid  input  1  request N valid (N = 0, 1).
REQ-006 SHALL have ports o_reqN_ready  output  1  request N accepted this cycle when high with valid.
REQ-007 SHALL have ports i_reqN_src_a, i_reqN_src_b  input  32  operands of request N.
REQ-008 SHALL have ports i_reqN_ctrl  input  5  ALU control of request N, same encoding as the shared ALU (ALU_CTRL_*/ALU_CMP_* defines).
REQ-009 SHALL have ports i_reqN_tag  input  TAG_W  opaque tag of request N.
REQ-010 SHALL have port o_rsp_valid  output  1  result register holds a result.
REQ-011 SHALL have port i_rsp_ready  input  1  consumer takes the result this cycle.
REQ-012 SHALL have ports o_rsp_result  output  32 and o_rsp_zero  output  1  registered ALU result and zero flag.
REQ-013 SHALL have ports o_rsp_id  output  1  winning requester, and o_rsp_tag  output  TAG_W  its tag.

Function
REQ-014 SHALL instantiate exactly one rv_alu, with its inputs driven by a mux selected by the current grant.
REQ-015 SHALL treat "slot free" as (!o_rsp_valid) or (o_rsp_valid and i_rsp_ready).
REQ-016 SHALL grant, when only one request is valid, that requester; when both are valid, the requester indicated by the round-robin pointer rr.
REQ-017 SHALL drive o_reqN_ready = grantN and slot free and !i_flush; at most one ready high per cycle; ready never high for an invalid request.
REQ-018 SHALL, on an accept (valid and ready), load result, zero, id and tag into the result register at the next edge and set o_rsp_valid; latency accept->o_rsp_valid is exactly 1 cycle.
REQ-019 SHALL set rr to the requester not granted after each accept; rr SHALL be unchanged in cycles without an accept.
REQ-020 SHALL keep o_rsp_* stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-021 SHALL, on consume without a new accept, clear o_rsp_valid at the next edge; consume and accept in the same cycle SHALL give back-to-back results with o_rsp_valid staying 1 (full throughput, one result per cycle).
REQ-022 SHALL, on i_flush=1, clear o_rsp_valid at the next edge, accept nothing that cycle, and leave rr unchanged; flush overrides a simultaneous consume.
REQ-023 SHALL allow a requester to change operands freely while not accepted; only values present in the accept cycle are captured.
REQ-024 SHALL produce o_rsp_result/o_rsp_zero identical to a standalone rv_alu evaluated on the accepted operands and ctrl.

Reset
REQ-025 SHALL, on i_reset asserted at any time, clear o_rsp_valid to 0, o_rsp_result to 0, o_rsp_zero to 0, o_rsp_id to 0, o_rsp_tag to 0, and rr to requester 0, with no clock required.
REQ-026 SHALL hold o_req0_ready and o_req1_ready at 0 while i_reset is high; an in-flight result is lost on reset.
REQ-027 SHALL accept the first request in the first clock edge after reset deassertion.

Verification
REQ-028 Single request: req0 ADD a=5, b=7, tag=3, i_rsp_ready=1 -> next cycle o_rsp_valid=1, result=12, zero=0, id=0, tag=3.
REQ-029 Contention: both valid every cycle, req0 SUB 9-9, req1 CMP_LTU 1<2, i_rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; results 0 (zero=1) and 1 (zero=0) alternate.
REQ-030 Backpressure: i_rsp_ready=0 for 3 cycles with a held result -> both readys 0, o_rsp_* unchanged; ready restored in the cycle i_rsp_ready returns to 1.
REQ-031 Throughput: req1 streams XOR operations with i_rsp_ready=1 for 8 cycles -> 8 consecutive results, o_rsp_valid continuously 1.
REQ-032 Flush: i_flush pulsed with a held result and i_rsp_ready=1 -> o_rsp_valid=0 next cycle, no accept that cycle, rr unchanged.
REQ-033 Async reset: i_reset asserted mid-stream between clock edges -> o_rsp_valid=0 immediately; after release, with both requesting, req0 granted first.
